// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mult_sequencer
// Purpose : Sequential signed multiplier driving HI/LO.
//           Works on operand magnitudes with unsigned shift-add, then fixes the sign.
// Revision: 1.0
// ============================================================================
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_lo_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier;
    logic               sign;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Unsigned magnitudes: the most negative value maps onto 2^(WIDTH-1) exactly.
    assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            addend <= '0;
            mplier <= '0;
            sign   <= 1'b0;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addend <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        sign   <= a[WIDTH-1] ^ b[WIDTH-1];
                        acc    <= '0;
                        count  <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // The multiplicand walks left while the multiplier walks right.
                    if (mplier[0]) begin
                        acc <= acc + addend;
                    end
                    addend <= addend << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    {hi, lo} <= sign ? (~acc + 1'b1) : acc;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign stall     = busy & (start | rd_hi | rd_lo);
    assign hi_lo_out = rd_hi ? hi : lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_sequencer
// Purpose : Self-checking bench for mult_sequencer against a latency/product model.
// Revision: 1.0
// ============================================================================
module tb_mult_sequencer;

    localparam int WIDTH = 32;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  a     = '0;
    logic [WIDTH-1:0]  b     = '0;
    logic              rd_hi = 1'b0;
    logic              rd_lo = 1'b0;
    logic              busy;
    logic              stall;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi_lo_out;

    mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .rd_hi     (rd_hi),
        .rd_lo     (rd_lo),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .hi_lo_out (hi_lo_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    // Reference model: an accepted request completes WIDTH+1 edges later.
    int          m_rem  = 0;
    logic [63:0] m_prod = '0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic        m_done = 1'b0;
    int          cyc    = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem  = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (start === 1'b1) begin
                    m_rem  = WIDTH + 1;
                    m_prod = ref_prod(a, b);
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi   = m_prod[63:32];
                    m_lo   = m_prod[31:0];
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) cyc++;

    int busy_cnt  = 0;
    int done_cnt  = 0;
    int last_done = 0;
    int prev_done = 0;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("busy", 64'(busy), 64'(m_rem != 0));
            chk("stall", 64'(stall), 64'((m_rem != 0) && (start || rd_hi || rd_lo)));
            chk("done", 64'(done), 64'(m_done));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("hi_lo_out", 64'(hi_lo_out), 64'(rd_hi ? m_hi : m_lo));
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                prev_done = last_done;
                last_done = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_rem != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(n < 100), 64'(1));
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(n < 100), 64'(1));
    endtask

    task automatic do_mul(input logic [31:0] x, input logic [31:0] y);
        wait_idle();
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
    endtask

    logic [63:0] exp_p;
    int          acc_cyc;
    int          dcnt0;

    initial begin
        // Reset state
        #2;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hilo", {hi, lo}, 64'(0));
        repeat (2) tick();

        // Accept on the first edge after reset release; 7*6
        reset = 1'b0;
        a     = 32'd7;
        b     = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        chk("p7x6_hi", 64'(hi), 64'h0);
        chk("p7x6_lo", 64'(lo), 64'h2A);
        @(negedge clk);
        #1;
        chk("p7x6_busy_cycles", 64'(busy_cnt), 64'(33));
        chk("p7x6_done_pulses", 64'(done_cnt), 64'(1));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(done), 64'(0));

        // Sign corner cases
        do_mul(32'hFFFF_FFFF, 32'h1);
        chk("m1x1", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        do_mul(32'h8000_0000, 32'h8000_0000);
        chk("min_sq", {hi, lo}, 64'h4000_0000_0000_0000);

        // rd_lo held while busy: stall until the done cycle
        wait_idle();
        a     = 32'd3;
        b     = 32'hFFFF_FFFB;
        start = 1'b1;
        tick();
        start = 1'b0;
        rd_lo = 1'b1;
        for (int n = 0; n < 100 && done !== 1'b1; n++) begin
            chk("stall_rd_lo", 64'(stall), 64'(1));
            tick();
        end
        chk("stall_done_cycle", 64'(stall), 64'(0));
        chk("rd_lo_new", 64'(hi_lo_out), 64'hFFFF_FFF1);
        rd_hi = 1'b1;
        #1;
        chk("rd_both_hi", 64'(hi_lo_out), 64'hFFFF_FFFF);
        rd_hi = 1'b0;
        rd_lo = 1'b0;

        // start held during busy, operands changing mid-operation
        wait_idle();
        a     = 32'd100;
        b     = 32'hFFFF_FFFD;
        start = 1'b1;
        tick();
        for (int n = 0; n < 100 && done !== 1'b1; n++) begin
            a = $urandom;
            b = $urandom;
            tick();
        end
        chk("held_orig_ops", {hi, lo}, 64'hFFFF_FFFF_FFFF_FED4);
        a = 32'd5;
        b = 32'd9;
        tick();
        start = 1'b0;
        wait_done();
        chk("b2b_second", {hi, lo}, 64'd45);
        @(negedge clk);
        #1;
        chk("b2b_spacing", 64'(last_done - prev_done), 64'(34));
        @(posedge clk);
        #1;

        // Reset in CALC cycle 10
        wait_idle();
        a     = 32'd1000;
        b     = 32'd2000;
        start = 1'b1;
        tick();
        start = 1'b0;
        rd_lo = 1'b1;
        repeat (10) tick();
        dcnt0 = done_cnt;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_stall", 64'(stall), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_hilo", {hi, lo}, 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_lo = 1'b0;
        a     = 32'hFFFF_FFF9;
        b     = 32'd9;
        start = 1'b1;
        tick();
        acc_cyc = cyc;
        start   = 1'b0;
        wait_done();
        chk("post_rst_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFC1);
        chk("post_rst_latency", 64'(cyc - acc_cyc), 64'(33));
        @(negedge clk);
        #1;
        chk("no_aborted_done", 64'(done_cnt - dcnt0), 64'(1));
        @(posedge clk);
        #1;

        // Random signed operands with random reads and stray starts
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            wait_idle();
            case ($urandom_range(0, 7))
                0: x = 32'h8000_0000;
                1: x = 32'hFFFF_FFFF;
                2: x = 32'h0;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: y = 32'h8000_0000;
                1: y = 32'h7FFF_FFFF;
                2: y = 32'h0;
                default: y = $urandom;
            endcase
            exp_p = ref_prod(x, y);
            a     = x;
            b     = y;
            start = 1'b1;
            tick();
            for (int n = 0; n < 100 && done !== 1'b1; n++) begin
                start = ($urandom_range(0, 3) == 0);
                rd_hi = $urandom_range(0, 1);
                rd_lo = $urandom_range(0, 1);
                a     = $urandom;
                b     = $urandom;
                tick();
            end
            chk("rand_prod", {hi, lo}, exp_p);
        end
        start = 1'b0;
        rd_hi = 1'b0;
        rd_lo = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  multiply request from decode (hi_lo_write); held by the pipeline until accepted.
REQ-005 Port a  input  WIDTH  signed multiplicand (rs value).
REQ-006 Port b  input  WIDTH  signed multiplier (rt value).
REQ-007 Port rd_hi  input  1  mfhi in decode.
REQ-008 Port rd_lo  input  1  mflo in decode.
REQ-009 Port busy  output  1  high while a multiply is in progress.
REQ-010 Port stall  output  1  pipeline freeze request.
REQ-011 Port done  output  1  one-cycle pulse when HI/LO have been updated.
REQ-012 Port hi  output  WIDTH  HI register.
REQ-013 Port lo  output  WIDTH  LO register.
REQ-014 Port hi_lo_out  output  WIDTH  hi if rd_hi, else lo (combinational select).

Function
REQ-015 The FSM SHALL have states IDLE, CALC and SIGN; busy = (state != IDLE).
REQ-016 In IDLE with start=1, the next edge SHALL latch |a|, |b| and sign = a[MSB]^b[MSB], clear the 2*WIDTH accumulator and a count to 0, and enter CALC.
REQ-017 CALC SHALL perform one unsigned shift-add step per cycle (add shifted |a| when the current bit of |b| is 1) for exactly WIDTH cycles, then enter SIGN.
REQ-018 Magnitudes SHALL be taken as WIDTH-bit unsigned, so -2^(WIDTH-1) has magnitude 2^(WIDTH-1) without overflow.
REQ-019 SIGN SHALL last one cycle; at its closing edge {hi,lo} SHALL load the accumulator, two's-complement negated over 2*WIDTH bits if sign=1; the state SHALL return to IDLE.
REQ-020 done SHALL be high for exactly the one cycle following the SIGN edge, and low otherwise.
REQ-021 Latency: with start accepted at edge E0, hi/lo SHALL update at edge E0+WIDTH+1 (E0+33 for WIDTH=32); busy SHALL be high for WIDTH+1 cycles.
REQ-022 hi and lo SHALL change only at the SIGN closing edge or on reset.
REQ-023 stall SHALL equal busy & (start | rd_hi | rd_lo); stall SHALL be 0 in IDLE.
REQ-024 start while busy SHALL be ignored by the FSM (no restart, no operand relatch); a start still asserted in IDLE SHALL be accepted then.
REQ-025 Operands a and b SHALL be sampled only at the accept edge; later changes SHALL not affect the result.
REQ-026 rd_hi and rd_lo both high SHALL select hi on hi_lo_out.
REQ-027 In the done cycle, rd_hi/rd_lo SHALL see the new HI/LO with no stall.
REQ-028 start in the done cycle SHALL be accepted (back-to-back multiplies, no idle gap).
REQ-029 The product SHALL equal the signed 2*WIDTH-bit product of a and b for all input values.

Reset
REQ-030 Asserting reset SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, stall=0, done=0, and clear the count, accumulator and sign, including mid-CALC or mid-SIGN.
REQ-031 After reset deassertion the block SHALL accept a new start on the first following edge.

Verification
REQ-032 a=7, b=6, start one cycle -> busy 33 cycles, done pulse once, hi=0x00000000, lo=0x0000002A.
REQ-033 a=0xFFFFFFFF (-1), b=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 rd_lo held from the cycle after accept -> stall=1 until done cycle, stall=0 in done cycle with hi_lo_out=new lo; rd_hi&rd_lo -> hi_lo_out=hi.
REQ-035 start held during busy with a/b changed mid-operation -> result reflects original operands, second multiply starts in done cycle, second done exactly 34 cycles after first.
REQ-036 reset pulsed at CALC cycle 10 -> all outputs 0 asynchronously, no done pulse, next start yields a correct product at nominal latency.
REQ-037 1000 random signed a/b pairs -> {hi,lo} matches the 64-bit signed reference product every time.
